// File: rtl/seg7_hex_capture.sv
// Receive side of the seven-segment display path: filters scanned active-low
// segment patterns per digit, decodes them back to nibbles and pairs them into bytes.
module seg7_hex_capture #(
    parameter int STABLE_CNT = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [0:6] seg_in,
    input  logic       dig,
    input  logic       seg_valid,
    input  logic       clr_err,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] STABLE = STABLE_CNT[3:0];

    // Decode result layout: {legal, blank, nibble}.
    function automatic logic [5:0] decode(input logic [0:6] p);
        case (p)
            7'b0000001: decode = {2'b10, 4'h0};
            7'b1001111: decode = {2'b10, 4'h1};
            7'b0010010: decode = {2'b10, 4'h2};
            7'b0000110: decode = {2'b10, 4'h3};
            7'b1001100: decode = {2'b10, 4'h4};
            7'b0100100: decode = {2'b10, 4'h5};
            7'b0100000: decode = {2'b10, 4'h6};
            7'b0001111: decode = {2'b10, 4'h7};
            7'b0000000: decode = {2'b10, 4'h8};
            7'b0000100: decode = {2'b10, 4'h9};
            7'b0001000: decode = {2'b10, 4'hA};
            7'b1100000: decode = {2'b10, 4'hB};
            7'b0110001: decode = {2'b10, 4'hC};
            7'b1000010: decode = {2'b10, 4'hD};
            7'b0110000: decode = {2'b10, 4'hE};
            7'b0111000: decode = {2'b10, 4'hF};
            7'b1111111: decode = {2'b01, 4'h0};
            default:    decode = 6'b00_0000;
        endcase
    endfunction

    logic [0:6] last_q [2];
    logic [3:0] cnt_q  [2];
    logic [3:0] nib_q  [2];
    logic [1:0] pend_q;

    logic       same;
    logic       accept;
    logic [5:0] dec;
    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_nib;

    always_comb begin
        same      = (seg_in == last_q[dig]);
        dec       = decode(seg_in);
        dec_legal = dec[5];
        dec_blank = dec[4];
        dec_nib   = dec[3:0];
        accept    = 1'b0;
        // A new pattern can only accept immediately when one sample is enough.
        if (seg_valid) begin
            if (same) accept = (cnt_q[dig] == STABLE - 4'd1);
            else      accept = (STABLE == 4'd1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            last_q[0]  <= 7'b1111111;
            last_q[1]  <= 7'b1111111;
            cnt_q[0]   <= 4'd0;
            cnt_q[1]   <= 4'd0;
            nib_q[0]   <= 4'd0;
            nib_q[1]   <= 4'd0;
            pend_q     <= 2'b00;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;

            if (seg_valid) begin
                if (same) begin
                    if (cnt_q[dig] < STABLE) cnt_q[dig] <= cnt_q[dig] + 4'd1;
                end else begin
                    last_q[dig] <= seg_in;
                    cnt_q[dig]  <= 4'd1;
                end
            end

            if (pend_q == 2'b11) begin
                byte_out   <= {nib_q[1], nib_q[0]};
                byte_valid <= 1'b1;
                pend_q     <= 2'b00;
            end

            // Placed after the emit so a same-edge accept keeps its digit pending.
            if (accept) begin
                if (dec_legal) begin
                    nib_q[dig]  <= dec_nib;
                    pend_q[dig] <= 1'b1;
                end else if (dec_blank) begin
                    pend_q[dig] <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end

            if (clr_err) begin
                err_cnt <= 8'h00;
            end else if (accept && !dec_legal && !dec_blank && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end

endmodule
